// File: rtl/fifo_sync_bram_pkg.sv
// Shared sizing helpers and default parameters for the BRAM-backed synchronous FIFO.
// Pointer width is one bit wider than the RAM address to carry the wrap bit.
package fifo_sync_bram_pkg;

  localparam int DEF_DATA_WIDTH = 8;
  localparam int DEF_ADDR_WIDTH = 4;
  localparam int DEF_AF_THRESH  = 14;

  function automatic int fifo_depth(input int addr_width);
    return 2 ** addr_width;
  endfunction

  function automatic int fifo_ptr_width(input int addr_width);
    return addr_width + 1;
  endfunction

endpackage

// File: rtl/bram_sync_dp.sv
// Dual-port block RAM with registered read on port B and write-first-free semantics.
// Both write ports are committed on a_clk; the FIFO drives a_clk and b_clk from one clock.
module bram_sync_dp #(
  parameter int RAM_DATA_WIDTH = 8,
  parameter int RAM_ADDR_WIDTH = 4
) (
  input  logic                      a_clk,
  input  logic                      b_clk,
  input  logic                      rst,
  input  logic                      a_wr,
  input  logic [RAM_ADDR_WIDTH-1:0] a_addr,
  input  logic [RAM_DATA_WIDTH-1:0] a_data_in,
  input  logic                      b_en,
  input  logic                      b_wr,
  input  logic [RAM_ADDR_WIDTH-1:0] b_addr,
  input  logic [RAM_DATA_WIDTH-1:0] b_data_in,
  output logic [RAM_DATA_WIDTH-1:0] b_data_out
);

  logic [RAM_DATA_WIDTH-1:0] mem [2**RAM_ADDR_WIDTH];
  logic [RAM_DATA_WIDTH-1:0] b_data_q;

  // Writes are suppressed during reset so a mid-stream reset cannot commit a stray word.
  always_ff @(posedge a_clk) begin
    if (!rst) begin
      if (a_wr) mem[a_addr] <= a_data_in;
      if (b_wr) mem[b_addr] <= b_data_in;
    end
  end

  always_ff @(posedge b_clk) begin
    if (b_en) b_data_q <= mem[b_addr];
  end

  assign b_data_out = b_data_q;

endmodule

// File: rtl/fifo_sync_bram.sv
// Single-clock FIFO controller around bram_sync_dp: port A writes, port B reads,
// registered flags, occupancy count and one-cycle overflow/underflow pulses.
module fifo_sync_bram
  import fifo_sync_bram_pkg::*;
#(
  parameter int DATA_WIDTH         = DEF_DATA_WIDTH,
  parameter int ADDR_WIDTH         = DEF_ADDR_WIDTH,
  parameter int ALMOST_FULL_THRESH = DEF_AF_THRESH
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wr_en,
  input  logic [DATA_WIDTH-1:0] wr_data,
  output logic                  full,
  output logic                  almost_full,
  output logic                  wr_overflow,
  input  logic                  rd_en,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic                  rd_valid,
  output logic                  empty,
  output logic                  rd_underflow,
  output logic [ADDR_WIDTH:0]   count
);

  localparam int PTR_WIDTH = fifo_ptr_width(ADDR_WIDTH);
  localparam logic [PTR_WIDTH-1:0] AF_THRESH = PTR_WIDTH'(ALMOST_FULL_THRESH);

  logic [PTR_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_WIDTH-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_WIDTH-1:0] count_q, count_d;
  logic                 empty_q, empty_d;
  logic                 full_q, full_d;
  logic                 almost_full_q, almost_full_d;
  logic                 rd_valid_q, rd_valid_d;
  logic                 wr_overflow_q, wr_overflow_d;
  logic                 rd_underflow_q, rd_underflow_d;
  logic                 wr_acc, rd_acc;

  always_comb begin
    // Acceptance uses the flags as registered at the start of the cycle, so
    // full+both keeps the read and empty+both keeps the write.
    wr_acc = wr_en & ~full_q;
    rd_acc = rd_en & ~empty_q;

    wr_ptr_d = wr_ptr_q + PTR_WIDTH'(wr_acc);
    rd_ptr_d = rd_ptr_q + PTR_WIDTH'(rd_acc);

    count_d = count_q;
    case ({wr_acc, rd_acc})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase

    empty_d       = (wr_ptr_d == rd_ptr_d);
    full_d        = (wr_ptr_d[ADDR_WIDTH-1:0] == rd_ptr_d[ADDR_WIDTH-1:0]) &&
                    (wr_ptr_d[ADDR_WIDTH] != rd_ptr_d[ADDR_WIDTH]);
    almost_full_d = (count_d >= AF_THRESH);

    rd_valid_d     = rd_acc;
    wr_overflow_d  = wr_en & full_q;
    rd_underflow_d = rd_en & empty_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q       <= '0;
      rd_ptr_q       <= '0;
      count_q        <= '0;
      empty_q        <= 1'b1;
      full_q         <= 1'b0;
      almost_full_q  <= 1'b0;
      rd_valid_q     <= 1'b0;
      wr_overflow_q  <= 1'b0;
      rd_underflow_q <= 1'b0;
    end else begin
      wr_ptr_q       <= wr_ptr_d;
      rd_ptr_q       <= rd_ptr_d;
      count_q        <= count_d;
      empty_q        <= empty_d;
      full_q         <= full_d;
      almost_full_q  <= almost_full_d;
      rd_valid_q     <= rd_valid_d;
      wr_overflow_q  <= wr_overflow_d;
      rd_underflow_q <= rd_underflow_d;
    end
  end

  bram_sync_dp #(
    .RAM_DATA_WIDTH (DATA_WIDTH),
    .RAM_ADDR_WIDTH (ADDR_WIDTH)
  ) u_ram (
    .a_clk      (clk),
    .b_clk      (clk),
    .rst        (rst),
    .a_wr       (wr_acc),
    .a_addr     (wr_ptr_q[ADDR_WIDTH-1:0]),
    .a_data_in  (wr_data),
    .b_en       (rd_acc),
    .b_wr       (1'b0),
    .b_addr     (rd_ptr_q[ADDR_WIDTH-1:0]),
    .b_data_in  ({DATA_WIDTH{1'b0}}),
    .b_data_out (rd_data)
  );

  assign full         = full_q;
  assign almost_full  = almost_full_q;
  assign wr_overflow  = wr_overflow_q;
  assign rd_valid     = rd_valid_q;
  assign empty        = empty_q;
  assign rd_underflow = rd_underflow_q;
  assign count        = count_q;

endmodule

// File: tb/tb_fifo_sync_bram.sv
// Directed bench for fifo_sync_bram: flags, ordering, overflow/underflow,
// simultaneous push/pop at the boundaries, pointer wrap and mid-stream reset.
module tb_fifo_sync_bram;

  logic       clk = 1'b0;
  logic       rst;
  logic       wr_en;
  logic [7:0] wr_data;
  logic       full, almost_full, wr_overflow;
  logic       rd_en;
  logic [7:0] rd_data;
  logic       rd_valid, empty, rd_underflow;
  logic [4:0] count;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  fifo_sync_bram #(
    .DATA_WIDTH         (8),
    .ADDR_WIDTH         (4),
    .ALMOST_FULL_THRESH (14)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .wr_en        (wr_en),
    .wr_data      (wr_data),
    .full         (full),
    .almost_full  (almost_full),
    .wr_overflow  (wr_overflow),
    .rd_en        (rd_en),
    .rd_data      (rd_data),
    .rd_valid     (rd_valid),
    .empty        (empty),
    .rd_underflow (rd_underflow),
    .count        (count)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s got=%0h want=%0h t=%0t", tag, obs, exp, $time);
    end else begin
      $display("ok   %s = %0h", tag, obs);
    end
  endtask

  // Advance one clock; outputs are sampled 1 time unit after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [7:0] d);
    wr_en = 1'b1; rd_en = 1'b0; wr_data = d;
    tick();
    wr_en = 1'b0;
  endtask

  logic [7:0] exp_q [$];
  int         mcount;
  int         sent;
  int         got;
  logic       wr_i, rd_i;
  logic [7:0] e;

  initial begin
    rst = 1'b1; wr_en = 1'b0; rd_en = 1'b0; wr_data = '0;
    tick(); tick();
    chk("rst_empty", 32'(empty), 32'd1);
    chk("rst_count", 32'(count), 32'd0);
    rst = 1'b0;

    // 1: idle after reset
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("idle_empty", 32'(empty), 32'd1);
      chk("idle_full", 32'(full), 32'd0);
      chk("idle_count", 32'(count), 32'd0);
      chk("idle_rdv", 32'(rd_valid), 32'd0);
    end

    // 2: three writes then three reads
    push(8'h11); chk("w1_count", 32'(count), 32'd1);
    push(8'h22); chk("w2_count", 32'(count), 32'd2);
    push(8'h33); chk("w3_count", 32'(count), 32'd3);
    rd_en = 1'b1;
    tick(); chk("r1_count", 32'(count), 32'd2); chk("r1_v", 32'(rd_valid), 32'd1); chk("r1_d", 32'(rd_data), 32'h11);
    tick(); chk("r2_count", 32'(count), 32'd1); chk("r2_v", 32'(rd_valid), 32'd1); chk("r2_d", 32'(rd_data), 32'h22);
    tick(); chk("r3_count", 32'(count), 32'd0); chk("r3_v", 32'(rd_valid), 32'd1); chk("r3_d", 32'(rd_data), 32'h33);
    rd_en = 1'b0;
    tick(); chk("r4_v", 32'(rd_valid), 32'd0); chk("r4_empty", 32'(empty), 32'd1);

    // 3: fill to full, overflow, drain
    for (int i = 0; i < 16; i++) begin
      push(8'(i));
      chk("fill_count", 32'(count), 32'(i + 1));
      chk("fill_af", 32'(almost_full), 32'((i + 1) >= 14));
      chk("fill_full", 32'(full), 32'((i + 1) == 16));
      chk("fill_empty", 32'(empty), 32'd0);
    end
    wr_en = 1'b1; wr_data = 8'hAA;
    tick(); chk("ovf_pulse", 32'(wr_overflow), 32'd1); chk("ovf_count", 32'(count), 32'd16);
    wr_en = 1'b0;
    tick(); chk("ovf_clear", 32'(wr_overflow), 32'd0); chk("ovf_count2", 32'(count), 32'd16);
    rd_en = 1'b1;
    for (int i = 0; i < 16; i++) begin
      tick();
      chk("drain_v", 32'(rd_valid), 32'd1);
      chk("drain_d", 32'(rd_data), 32'(i));
      chk("drain_count", 32'(count), 32'(15 - i));
    end
    rd_en = 1'b0;
    tick(); chk("drain_empty", 32'(empty), 32'd1); chk("drain_af", 32'(almost_full), 32'd0);

    // 4: underflow
    rd_en = 1'b1;
    tick(); chk("udf_pulse", 32'(rd_underflow), 32'd1); chk("udf_v", 32'(rd_valid), 32'd0); chk("udf_count", 32'(count), 32'd0);
    rd_en = 1'b0;
    tick(); chk("udf_clear", 32'(rd_underflow), 32'd0); chk("udf_v2", 32'(rd_valid), 32'd0);

    // 5a: simultaneous push/pop while full
    for (int i = 0; i < 16; i++) push(8'(8'h80 + i));
    chk("sf_full", 32'(full), 32'd1);
    wr_en = 1'b1; rd_en = 1'b1; wr_data = 8'hEE;
    tick();
    chk("sf_count", 32'(count), 32'd15); chk("sf_v", 32'(rd_valid), 32'd1);
    chk("sf_d", 32'(rd_data), 32'h80); chk("sf_ovf", 32'(wr_overflow), 32'd1); chk("sf_full2", 32'(full), 32'd0);
    wr_en = 1'b0;
    for (int i = 1; i < 16; i++) begin
      tick();
      chk("sf_drain_d", 32'(rd_data), 32'(8'h80 + i));
    end
    rd_en = 1'b0;
    tick(); chk("sf_empty", 32'(empty), 32'd1);

    // 5b: simultaneous push/pop while empty
    wr_en = 1'b1; rd_en = 1'b1; wr_data = 8'h5A;
    tick();
    chk("se_count", 32'(count), 32'd1); chk("se_udf", 32'(rd_underflow), 32'd1); chk("se_v", 32'(rd_valid), 32'd0);
    wr_en = 1'b0;
    tick();
    chk("se_rd_v", 32'(rd_valid), 32'd1); chk("se_rd_d", 32'(rd_data), 32'h5A); chk("se_count2", 32'(count), 32'd0);
    rd_en = 1'b0;
    tick();

    // 6a: 40-word stream with overlap around count 8, crossing the pointer wrap
    mcount = 0; sent = 0; got = 0;
    exp_q.delete();
    for (int cyc = 0; cyc < 200; cyc++) begin
      if (sent == 40 && mcount == 0) break;
      wr_i = (sent < 40);
      rd_i = (mcount >= 8) || (sent == 40 && mcount > 0);
      wr_en = wr_i; rd_en = rd_i; wr_data = 8'(sent * 7 + 3);
      tick();
      if (rd_i && mcount > 0) begin
        e = exp_q.pop_front();
        chk("stream_v", 32'(rd_valid), 32'd1);
        chk("stream_d", 32'(rd_data), 32'(e));
        got++;
        mcount--;
      end
      if (wr_i && mcount < 16) begin
        exp_q.push_back(8'(sent * 7 + 3));
        sent++;
        mcount++;
      end
      chk("stream_count", 32'(count), 32'(mcount));
    end
    wr_en = 1'b0; rd_en = 1'b0;
    chk("stream_got", 32'(got), 32'd40);
    tick(); chk("stream_empty", 32'(empty), 32'd1);

    // 6b: reset in the middle of traffic
    for (int i = 0; i < 5; i++) push(8'(8'hC0 + i));
    wr_en = 1'b1; rd_en = 1'b1; wr_data = 8'hDD; rst = 1'b1;
    tick();
    chk("mrst_count", 32'(count), 32'd0); chk("mrst_empty", 32'(empty), 32'd1);
    chk("mrst_v", 32'(rd_valid), 32'd0); chk("mrst_full", 32'(full), 32'd0);
    chk("mrst_ovf", 32'(wr_overflow), 32'd0);
    rst = 1'b0; wr_en = 1'b0; rd_en = 1'b0;
    tick();
    chk("post_empty", 32'(empty), 32'd1); chk("post_v", 32'(rd_valid), 32'd0);
    push(8'h3C);
    rd_en = 1'b1;
    tick(); chk("post_d", 32'(rd_data), 32'h3C); chk("post_v2", 32'(rd_valid), 32'd1);
    rd_en = 1'b0;
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
